// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised Moore serial pattern detector for a 1-bit stream. The pattern
// can be reloaded at run time. Matches can overlap or not, as selected by
// ovl_en. Input bits are qualified by in_valid. A saturating counter keeps a
// count of matches.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   synchronous active-low reset
//   in_valid   in   qualifies `in`; bits are sampled only when high
//   in         in   serial data bit, MSB of the pattern arrives first
//   ovl_en     in   1 = overlapping matches, 0 = restart after each match
//   pat_load   in   load pat_in as the new pattern and restart detection
//   pat_in     in   new pattern (PAT_W bits)
//   cnt_clr    in   clear match_cnt and cnt_sat
//   out        out  registered match flag (cs == PAT_W)
//   cs         out  number of pattern bits currently matched (0..PAT_W)
//   match_cnt  out  saturating match count
//   cnt_sat    out  sticky saturation flag
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
    parameter int               CNT_W   = 8,
    parameter int               CS_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    input  logic             ovl_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CS_W-1:0]  cs,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [CS_W-1:0]  CS_FULL = CS_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CS_W-1:0]  cs_q, cs_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [CS_W-1:0]  cs_eff;
    logic [CS_W-1:0]  ns;
    logic             hit;

    // The last cs received bits always equal the first cs pattern bits. So
    // the received history is fully described by (pat, cs), and no separate
    // shift register is needed. This returns the longest pattern prefix that
    // is also a suffix of {prefix(cur), bit_in}. That is the KMP fallback.
    // The k <= cur+1 limit keeps the result within the number of valid bits
    // received since the last restart.
    function automatic logic [CS_W-1:0] next_state(
        input logic [PAT_W-1:0] pat,
        input logic [CS_W-1:0]  cur,
        input logic             bit_in
    );
        logic [PAT_W:0]  pat_x;
        logic [PAT_W:0]  seq;
        logic [PAT_W:0]  ones;
        logic [PAT_W:0]  mask;
        logic [PAT_W:0]  pre;
        logic [CS_W-1:0] best;
        int              c;
        pat_x = {1'b0, pat};
        ones  = '1;
        c     = int'(cur);
        // The matched prefix is right-aligned, then the new bit is appended.
        seq   = ((pat_x >> (PAT_W - c)) << 1) | {{PAT_W{1'b0}}, bit_in};
        best  = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            mask = ones >> (PAT_W + 1 - k);
            pre  = pat_x >> (PAT_W - k);
            if ((k <= c + 1) && ((seq & mask) == pre)) begin
                best = CS_W'(k);
            end
        end
        return best;
    endfunction

    // In non-overlap mode a completed match discards the history. The bit
    // that follows a match is then evaluated as if from cs = 0.
    assign cs_eff = ((cs_q == CS_FULL) && !ovl_en) ? '0 : cs_q;
    assign ns     = next_state(pat_q, cs_eff, in);

    always_comb begin
        // NOTE: every signal gets a default first. Without this, a path that
        // skips an assignment would infer a latch.
        pat_d = pat_q;
        cs_d  = cs_q;
        out_d = out_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        hit   = 1'b0;

        // pat_load wins over in_valid. The bit presented in that cycle is dropped.
        if (pat_load) begin
            pat_d = pat_in;
            cs_d  = '0;
            out_d = 1'b0;
        end else if (in_valid) begin
            cs_d  = ns;
            out_d = (ns == CS_FULL);
            hit   = (ns == CS_FULL);
        end

        // A clear wins over a match in the same cycle.
        if (cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit) begin
            if (cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only. All flops then
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            pat_q <= PAT_RST;
            cs_q  <= '0;
            out_q <= 1'b0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
            cs_q  <= cs_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign out       = out_q;
    assign cs        = cs_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Directed bench for seq_detect_param with PAT_W=3, PAT_RST=3'b101, CNT_W=2.
// Inputs are driven just after a rising edge. Outputs are sampled 1 time unit
// after the rising edge that processes each input.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int PAT_W = 3;
    localparam int CNT_W = 2;
    localparam int CS_W  = $clog2(PAT_W + 1);

    logic             clk;
    logic             clr;
    logic             in_valid;
    logic             in_b;
    logic             ovl_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             out;
    logic [CS_W-1:0]  cs;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int checks = 0;
    int errors = 0;

    seq_detect_param #(
        .PAT_W   (PAT_W),
        .PAT_RST (3'b101),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in        (in_b),
        .ovl_en    (ovl_en),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .out       (out),
        .cs        (cs),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then wait until outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one valid bit, then check the resulting state and flag.
    task automatic send(input string tag, input logic b, input int exp_cs, input logic exp_out);
        in_valid = 1'b1;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        check({tag, ".cs"}, 32'(cs), 32'(exp_cs));
        check({tag, ".out"}, 32'(out), 32'(exp_out));
    endtask

    // Restart detection with a new pattern and clear the counter.
    task automatic restart(input logic [PAT_W-1:0] p, input logic do_clr);
        pat_load = 1'b1;
        pat_in   = p;
        cnt_clr  = do_clr;
        tick();
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        clr      = 1'b0;
        in_valid = 1'b0;
        in_b     = 1'b0;
        ovl_en   = 1'b1;
        pat_load = 1'b0;
        pat_in   = '0;
        cnt_clr  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst.cs", 32'(cs), 0);
        check("rst.out", 32'(out), 0);
        check("rst.cnt", 32'(match_cnt), 0);
        check("rst.sat", 32'(cnt_sat), 0);
        clr = 1'b1;

        // Overlap mode, pattern 101, bits 1 0 1 0 1
        ovl_en = 1'b1;
        send("ovl1", 1'b1, 1, 1'b0);
        send("ovl2", 1'b0, 2, 1'b0);
        send("ovl3", 1'b1, 3, 1'b1);
        send("ovl4", 1'b0, 2, 1'b0);
        send("ovl5", 1'b1, 3, 1'b1);
        check("ovl.cnt", 32'(match_cnt), 2);

        // Non-overlap mode, same bits
        restart(3'b101, 1'b1);
        check("nov.cnt0", 32'(match_cnt), 0);
        ovl_en = 1'b0;
        send("nov1", 1'b1, 1, 1'b0);
        send("nov2", 1'b0, 2, 1'b0);
        send("nov3", 1'b1, 3, 1'b1);
        send("nov4", 1'b0, 0, 1'b0);
        send("nov5", 1'b1, 1, 1'b0);
        check("nov.cnt", 32'(match_cnt), 1);

        // Valid gaps: 1, 0, 1 with three idle cycles after each bit
        restart(3'b101, 1'b1);
        ovl_en = 1'b1;
        send("gap1", 1'b1, 1, 1'b0);
        in_b = 1'b0;
        tick(); tick(); tick();
        check("gap1.hold", 32'(cs), 1);
        send("gap2", 1'b0, 2, 1'b0);
        in_b = 1'b1;
        tick(); tick(); tick();
        check("gap2.hold", 32'(cs), 2);
        send("gap3", 1'b1, 3, 1'b1);
        in_b = 1'b0;
        tick(); tick(); tick();
        check("gap3.hold.cs", 32'(cs), 3);
        check("gap3.hold.out", 32'(out), 1);
        check("gap.cnt", 32'(match_cnt), 1);

        // Pattern load: the same-cycle bit is ignored and the counter is kept
        restart(3'b101, 1'b0);
        send("pl1", 1'b1, 1, 1'b0);
        send("pl2", 1'b0, 2, 1'b0);
        pat_load = 1'b1;
        pat_in   = 3'b110;
        in_valid = 1'b1;
        in_b     = 1'b1;
        tick();
        pat_load = 1'b0;
        in_valid = 1'b0;
        check("pl.cs", 32'(cs), 0);
        check("pl.out", 32'(out), 0);
        check("pl.cnt", 32'(match_cnt), 1);
        send("pl110a", 1'b1, 1, 1'b0);
        send("pl110b", 1'b1, 2, 1'b0);
        send("pl110c", 1'b0, 3, 1'b1);
        check("pl110.cnt", 32'(match_cnt), 2);
        send("pl101a", 1'b1, 1, 1'b0);
        send("pl101b", 1'b0, 0, 1'b0);
        send("pl101c", 1'b1, 1, 1'b0);
        check("pl101.cnt", 32'(match_cnt), 2);

        // Saturation with CNT_W=2: 1010101010 gives four matches
        restart(3'b101, 1'b1);
        ovl_en = 1'b1;
        send("sat1", 1'b1, 1, 1'b0);
        send("sat2", 1'b0, 2, 1'b0);
        send("sat3", 1'b1, 3, 1'b1);
        send("sat4", 1'b0, 2, 1'b0);
        send("sat5", 1'b1, 3, 1'b1);
        send("sat6", 1'b0, 2, 1'b0);
        send("sat7", 1'b1, 3, 1'b1);
        check("sat7.cnt", 32'(match_cnt), 3);
        send("sat8", 1'b0, 2, 1'b0);
        send("sat9", 1'b1, 3, 1'b1);
        send("sat10", 1'b0, 2, 1'b0);
        check("sat.cnt", 32'(match_cnt), 3);
        check("sat.flag", 32'(cnt_sat), 1);

        // cnt_clr coinciding with a match: the clear wins
        cnt_clr = 1'b1;
        send("clrhit", 1'b1, 3, 1'b1);
        cnt_clr = 1'b0;
        check("clrhit.cnt", 32'(match_cnt), 0);
        check("clrhit.sat", 32'(cnt_sat), 0);

        // Reset mid-operation. Reset overrides a valid bit and the pattern returns to 101.
        send("pre1", 1'b0, 2, 1'b0);
        send("pre2", 1'b1, 3, 1'b1);
        check("pre.cnt", 32'(match_cnt), 1);
        restart(3'b100, 1'b0);
        send("mid1", 1'b1, 1, 1'b0);
        send("mid2", 1'b0, 2, 1'b0);
        clr      = 1'b0;
        in_valid = 1'b1;
        in_b     = 1'b0;
        tick();
        clr      = 1'b1;
        in_valid = 1'b0;
        check("mid.rst.cs", 32'(cs), 0);
        check("mid.rst.out", 32'(out), 0);
        check("mid.rst.cnt", 32'(match_cnt), 0);
        send("post1", 1'b1, 1, 1'b0);
        send("post2", 1'b0, 2, 1'b0);
        send("post3", 1'b1, 3, 1'b1);
        check("post.cnt", 32'(match_cnt), 1);

        // All-equal pattern 111: overlap gives matches on bits 3 and 4
        restart(3'b111, 1'b1);
        ovl_en = 1'b1;
        send("all1", 1'b1, 1, 1'b0);
        send("all2", 1'b1, 2, 1'b0);
        send("all3", 1'b1, 3, 1'b1);
        send("all4", 1'b1, 3, 1'b1);
        check("all.cnt", 32'(match_cnt), 2);
        ovl_en = 1'b0;
        send("all5", 1'b1, 1, 1'b0);
        send("all6", 1'b0, 0, 1'b0);
        check("all.cnt2", 32'(match_cnt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
